// File: rtl/mult_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mult_control_fsm
// Description : Sequencing controller for the 8-bit signed add-shift
//               multiplier.  A single FSM with a 3-bit iteration counter
//               issues clear/load/add/subtract/shift strobes so that X:A:B
//               holds the 16-bit two's-complement product S x B.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_control_fsm (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_a_load_b_i,
  input  logic       execute_i,
  input  logic       m_i,
  output logic       clr_ld_o,
  output logic       clr_xa_o,
  output logic       add_o,
  output logic       sub_o,
  output logic       shift_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [2:0] count_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  localparam logic [2:0] C_LAST_ITER = 3'd7;

  state_t     state_q, state_d;
  logic [2:0] count_q, count_d;
  logic       clr_xa_q, clr_xa_d;
  logic       shift_q, shift_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Next-state and counter logic; state-only outputs are decoded from the
  // next state so they can be registered and line up with the state itself.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        // Load request wins over Execute when both are high.
        if (!clear_a_load_b_i && execute_i) begin
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        count_d = 3'd0;
        state_d = S_ADD;
      end
      S_ADD: begin
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        count_d = count_q + 3'd1;
        state_d = (count_q == C_LAST_ITER) ? S_HOLD : S_ADD;
      end
      S_HOLD: begin
        // Execute must drop before a new run can start.
        if (!execute_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = 3'd0;
      end
    endcase

    clr_xa_d = (state_d == S_CLEAR);
    shift_d  = (state_d == S_SHIFT);
    busy_d   = (state_d == S_CLEAR) || (state_d == S_ADD) || (state_d == S_SHIFT);
    done_d   = (state_d == S_HOLD);
  end

  // State, counter and registered outputs; reset aborts any run at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      count_q  <= 3'd0;
      clr_xa_q <= 1'b0;
      shift_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      clr_xa_q <= clr_xa_d;
      shift_q  <= shift_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // The last iteration subtracts because B[7] carries weight -128.
  assign add_o    = (state_q == S_ADD) && m_i && (count_q != C_LAST_ITER);
  assign sub_o    = (state_q == S_ADD) && m_i && (count_q == C_LAST_ITER);
  // Loading is only honoured while no run is in progress.
  assign clr_ld_o = clear_a_load_b_i && ((state_q == S_IDLE) || (state_q == S_HOLD));

  assign clr_xa_o = clr_xa_q;
  assign shift_o  = shift_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign count_o  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_control_fsm
// Description : Directed bench for mult_control_fsm with a behavioral
//               X:A:B datapath model driven by the controller strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_control_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clb = 1'b0;
  logic       exec = 1'b0;
  logic       m;
  logic       clr_ld, clr_xa, add, sub, shift, busy, done;
  logic [2:0] count;

  // Datapath model state
  logic       mX = 1'b0;
  logic [7:0] mA = 8'h00;
  logic [7:0] mB = 8'h00;
  logic [7:0] sw = 8'h00;
  logic [7:0] S  = 8'h00;
  logic [8:0] w_sum, w_dif;

  int checks = 0;
  int failures = 0;

  mult_control_fsm dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .clear_a_load_b_i (clb),
    .execute_i        (exec),
    .m_i              (m),
    .clr_ld_o         (clr_ld),
    .clr_xa_o         (clr_xa),
    .add_o            (add),
    .sub_o            (sub),
    .shift_o          (shift),
    .busy_o           (busy),
    .done_o           (done),
    .count_o          (count)
  );

  always #5 clk = ~clk;

  assign m     = mB[0];
  assign w_sum = {mA[7], mA} + {S[7], S};
  assign w_dif = {mA[7], mA} - {S[7], S};

  // Behavioral register unit reacting to the controller strobes.
  always @(posedge clk) begin
    if (clr_ld) begin
      mX <= 1'b0; mA <= 8'h00; mB <= sw;
    end else if (clr_xa) begin
      mX <= 1'b0; mA <= 8'h00;
    end else if (add) begin
      mX <= w_sum[8]; mA <= w_sum[7:0];
    end else if (sub) begin
      mX <= w_dif[8]; mA <= w_dif[7:0];
    end else if (shift) begin
      mA <= {mX, mA[7:1]};
      mB <= {mA[0], mB[7:1]};
    end
  end

  task automatic load_b(input logic [7:0] v);
    @(negedge clk);
    sw  = v;
    clb = 1'b1;
    #1;
    checks++;
    if (clr_ld !== 1'b1) begin
      failures++;
      $display("FAIL load_clr_ld: got %b expected 1", clr_ld);
    end
    @(negedge clk);
    clb = 1'b0;
  endtask

  // One-cycle Execute pulse; collects strobe statistics until Done.
  task automatic run_pulse(output int busy_n, output int shift_n, output int add_n,
                           output int sub_n, output int sub7_n, output int done_cyc);
    busy_n = 0; shift_n = 0; add_n = 0; sub_n = 0; sub7_n = 0; done_cyc = 0;
    exec = 1'b1;
    for (int i = 1; i <= 40 && done_cyc == 0; i++) begin
      @(negedge clk);
      if (i == 1) exec = 1'b0;
      if (busy  === 1'b1) busy_n++;
      if (shift === 1'b1) shift_n++;
      if (add   === 1'b1) add_n++;
      if (sub   === 1'b1) sub_n++;
      if (sub === 1'b1 && count === 3'd7) sub7_n++;
      if (done  === 1'b1) done_cyc = i;
    end
  endtask

  task automatic check_result(input string name, input logic ex, input logic [7:0] ea,
                              input logic [7:0] eb);
    checks++;
    if ({mX, mA, mB} !== {ex, ea, eb}) begin
      failures++;
      $display("FAIL %s_XAB: got %b_%h_%h expected %b_%h_%h", name, mX, mA, mB, ex, ea, eb);
    end
  endtask

  task automatic check_release(input string name);
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin
      failures++;
      $display("FAIL %s_release: done,busy got %b%b expected 00", name, done, busy);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({clr_ld, clr_xa, add, sub, shift, busy, done, count} !== 10'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 0", {clr_ld, clr_xa, add, sub, shift, busy, done, count});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({clr_ld, clr_xa, add, sub, shift, busy, done, count} !== 10'b0) begin
        failures++;
        $display("FAIL idle_after_reset cyc %0d: got %b expected 0", i,
                 {clr_ld, clr_xa, add, sub, shift, busy, done, count});
      end
    end
  endtask

  task automatic test_basic(input string name, input logic [7:0] b, input logic [7:0] s,
                            input int e_add, input int e_sub, input logic ex,
                            input logic [7:0] ea, input logic [7:0] eb);
    int bn, sn, an, subn, s7, dc;
    load_b(b);
    S = s;
    run_pulse(bn, sn, an, subn, s7, dc);
    checks++;
    if (dc != 18) begin
      failures++;
      $display("FAIL %s_done_cycle: got %0d expected 18", name, dc);
    end
    checks++;
    if (bn != 17 || sn != 8) begin
      failures++;
      $display("FAIL %s_busy_shift: got busy=%0d shift=%0d expected 17/8", name, bn, sn);
    end
    checks++;
    if (an != e_add || subn != e_sub || s7 != e_sub) begin
      failures++;
      $display("FAIL %s_add_sub: got add=%0d sub=%0d sub@7=%0d expected %0d/%0d/%0d",
               name, an, subn, s7, e_add, e_sub, e_sub);
    end
    checks++;
    if (count !== 3'd0) begin
      failures++;
      $display("FAIL %s_hold_count: got %0d expected 0", name, count);
    end
    check_result(name, ex, ea, eb);
    check_release(name);
  endtask

  task automatic test_execute_held();
    int dc;
    load_b(8'h03);
    S = 8'h07;
    exec = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== (i <= 17) || done !== (i >= 18)) begin
        failures++;
        $display("FAIL held cyc %0d: busy,done got %b%b expected %b%b", i, busy, done,
                 (i <= 17), (i >= 18));
      end
      if (i == 18) check_result("held", 1'b0, 8'h00, 8'h15);
      if (i == 30) begin
        sw  = 8'h03;
        clb = 1'b1;
        #1;
        checks++;
        if (clr_ld !== 1'b1) begin
          failures++;
          $display("FAIL hold_clr_ld: got %b expected 1", clr_ld);
        end
      end
      if (i == 31) clb = 1'b0;
    end
    exec = 1'b0;
    check_release("held");
    @(negedge clk);
    exec = 1'b1;
    @(negedge clk);
    exec = 1'b0;
    checks++;
    if ({clr_xa, busy} !== 2'b11) begin
      failures++;
      $display("FAIL rerun_clear: clr_xa,busy got %b%b expected 11", clr_xa, busy);
    end
    dc = 0;
    for (int i = 2; i <= 40 && dc == 0; i++) begin
      @(negedge clk);
      if (done === 1'b1) dc = i;
    end
    checks++;
    if (dc != 18) begin
      failures++;
      $display("FAIL rerun_done_cycle: got %0d expected 18", dc);
    end
    check_result("rerun", 1'b0, 8'h00, 8'h15);
    check_release("rerun");
  endtask

  task automatic test_reset_midrun();
    load_b(8'h03);
    S = 8'h07;
    exec = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) exec = 1'b0;
    end
    checks++;
    if (busy !== 1'b1 || count !== 3'd2) begin
      failures++;
      $display("FAIL midrun_pre: busy=%b count=%0d expected 1/2", busy, count);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, shift, done, clr_xa, count} !== 7'b0) begin
      failures++;
      $display("FAIL midrun_abort: got %b expected 0", {busy, shift, done, clr_xa, count});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sw   = 8'h05;
    clb  = 1'b1;
    exec = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({clr_ld, clr_xa, busy} !== 3'b100) begin
        failures++;
        $display("FAIL both_high cyc %0d: clr_ld,clr_xa,busy got %b expected 100", i,
                 {clr_ld, clr_xa, busy});
      end
      @(negedge clk);
    end
    clb  = 1'b0;
    exec = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL both_high_after: busy,done got %b%b expected 00", busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_basic("pos_pos", 8'h03, 8'h07, 2, 0, 1'b0, 8'h00, 8'h15);
    test_basic("neg_s",   8'h03, 8'hFE, 2, 0, 1'b1, 8'hFF, 8'hFA);
    test_basic("neg_b",   8'h80, 8'h02, 0, 1, 1'b1, 8'hFF, 8'h00);
    test_execute_held();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_control_fsm.md
# mult_control_fsm

Sequencing controller for the 8-bit signed add-shift multiplier datapath: the X flip-flop, the 8-bit A accumulator, the 8-bit B multiplier register and the 9-bit adder/subtractor. It replaces the separate control unit and counter8 with a single FSM and an internal 3-bit iteration counter. It issues one-cycle clear, load, add, subtract and shift strobes so that X:A:B holds the 16-bit two's-complement product of S × B after one Execute press.

## Interface
- Parameters: none. Width is fixed at 8 iterations with a 3-bit counter.
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high; forces IDLE immediately.
- ClearA_LoadB  in  1  synchronized active-high level: clear X and A, load B from switches.
- Execute  in  1  synchronized active-high level: start one multiplication.
- M  in  1  current B[0], taken from the register unit.
- Clr_Ld  out  1  clear X and A, and load B; datapath acts on the same edge.
- Clr_XA  out  1  clear X and A only.
- Add  out  1  A ← A + S, with X ← sign of the 9-bit sum.
- Sub  out  1  A ← A − S, with X ← sign of the 9-bit difference.
- Shift  out  1  arithmetic right shift of X:A:B; X is unchanged.
- Busy  out  1  a multiplication is in progress.
- Done  out  1  result valid; held until Execute is released.
- Count  out  3  iteration index, for debug and the HEX display.

## Operation
- States:
  - IDLE: wait for a command.
  - CLEAR: one cycle, clears X and A before the run.
  - ADD: one cycle per iteration.
  - SHIFT: one cycle per iteration.
  - HOLD: result valid, waiting for Execute release.
- IDLE:
  - ClearA_LoadB=1: assert Clr_Ld each cycle it is high; stay in IDLE.
  - Otherwise, Execute=1: go to CLEAR.
  - ClearA_LoadB has priority over Execute when both are high.
- CLEAR: assert Clr_XA; Count ← 0; go to ADD.
- ADD:
  - Count ≠ 7: Add = M.
  - Count = 7: Sub = M.
  - Add and Sub are never asserted together. No strobe is asserted when M=0, but the cycle is still spent.
  - Next state is always SHIFT.
- SHIFT:
  - Assert Shift; Count ← Count + 1, wrapping 7→0.
  - Count was 7: go to HOLD; otherwise go to ADD.
- HOLD:
  - Done=1; no datapath strobes.
  - Execute=0: go to IDLE.
  - ClearA_LoadB=1: assert Clr_Ld and stay in HOLD.
- Busy=1 in CLEAR, ADD and SHIFT. While Busy, ClearA_LoadB and Execute changes are ignored.
- M is only meaningful in ADD. B changes only on Shift edges, so M is stable throughout each ADD cycle.
- Add, Sub and Clr_Ld depend combinationally on M or ClearA_LoadB. All other outputs are decoded from state only.
- Arithmetic note: the final step subtracts because B[7] has weight −128. X keeps the 9th bit so the shift stays sign-correct across overflow of A.

## Timing
- Reset (async): state=IDLE, Count=0. All outputs are 0: Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done.
- Reset mid-run: abort immediately. Datapath contents are undefined until the next Clr_Ld.
- Latency: with Execute sampled high in IDLE at edge 0:
  - CLEAR occupies cycle 1.
  - ADD/SHIFT pairs occupy cycles 2–17.
  - HOLD is entered at edge 17; Done is first high in cycle 18.
- The run is a fixed 17 cycles, independent of operand values.
- Exactly 8 Shift pulses per run. Add and Sub pulses total at most 8.
- Execute held high through HOLD must not restart the run. A new run requires Execute=0 for at least one cycle, then 1 again.
- Execute pulse of one cycle in IDLE is sufficient to complete a full run.
- Back-to-back runs without a reload are legal: B holds the previous low product byte and is used as the new multiplier.

## Test plan
The bench pairs the FSM with a behavioral X:A:B datapath model and checks X:A:B at Done.

- Reset asserted, then released with all inputs 0 → every output stays 0 and the FSM stays in IDLE for 20 cycles.
- ClearA_LoadB with switches=0x03, then S=0x07 and Execute for 1 cycle → Busy high for exactly 17 cycles, 8 Shift pulses, Done high; A=0x00, B=0x15, X=0.
- Load B=0x03, S=0xFE, Execute → A=0xFF, B=0xFA (−6), X=1; Sub is never asserted because B[7]=0.
- Load B=0x80, S=0x02, Execute → a single Sub pulse at Count=7 and no Add pulses; A=0xFF, B=0x00 (−256).
- Execute held high for 40 cycles → exactly one run, Done held from cycle 18. Release Execute → IDLE next cycle. Press again → a second run starts from CLEAR.
- Reset asserted at cycle 6 of a run → Busy=0 and Shift=0 immediately, Count=0. Execute with ClearA_LoadB both high in IDLE → Clr_Ld asserted and no run starts.
